mdu_iter: RTL and testbench
===========================

// Module: mdu_iter
// PURPOSE
// - Iterative RV32M multiply/divide unit. Sits directly downstream of the EX-stage operand-B 2:1 mux.
// - mdu_b is that mux's output; mdu_a is rs1 data.
// - Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with one shift-add/shift-subtract step per cycle.
// - The EX stage stalls while mdu_busy=1 and captures mdu_result on mdu_done.
// PARAMETERS
// - XLEN      32   operand/result width; only 32 is supported
// PORTS
// - clk          in   1     single clock, rising edge
// - rst_n        in   1     asynchronous, active-low reset
// - mdu_start    in   1     request; sampled when state is IDLE or DONE
// - mdu_op       in   3     funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
// - mdu_a        in   32    operand A (rs1)
// - mdu_b        in   32    operand B (operand-mux output)
// - mdu_flush    in   1     synchronous abort (pipeline flush)
// - mdu_busy     out  1     high in PREP and CALC
// - mdu_done     out  1     one-cycle pulse; mdu_result valid in that cycle
// - mdu_result   out  32    result; holds its value until the next done
// BEHAVIOUR
// - One clock domain, clk. Reset is asynchronous and active-low on rst_n.
// - Reset: state=IDLE, mdu_busy=0, mdu_done=0, mdu_result=0, all internal registers 0.
// - Reset takes effect immediately, including mid-operation.
// - FSM states: IDLE, PREP, CALC, DONE.
// - IDLE: if start=1, latch op/a/b and go to PREP.
// - PREP: compute operand magnitudes and result-sign flags. Detect special cases.
//   - Special case present: go to DONE with the special result.
//   - Otherwise: go to CALC with the iteration counter = 31.
// - CALC: one iteration per cycle; counter decrements; at 0 go to DONE.
// - DONE: done=1; result is the sign-corrected value.
//   - If start=1 in DONE: latch the new operands and go to PREP (back-to-back).
//   - Otherwise go to IDLE.
// - Latency, with start sampled at edge T:
//   - PREP occupies T+1, CALC occupies T+2..T+33, done occurs at T+34.
//   - Special cases: done at T+2.
// - mdu_start is ignored while busy. mdu_op/a/b are don't-care after the sampling edge.
// - Multiply:
//   - Unsigned 32x32 -> 64-bit product built from magnitudes, one multiplier bit per cycle.
//   - The 64-bit result is negated when the result sign is negative.
//   - MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32].
//   - Signedness: MULH treats a and b as signed; MULHSU treats only a as signed; MULHU treats both as unsigned.
// - Divide: restoring, on magnitudes.
//   - Quotient is negative iff the dividend and divisor signs differ (signed ops only).
//   - Remainder takes the sign of the dividend.
// - Special cases, resolved in PREP:
//   - b==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> a.
//   - DIV with a=0x80000000, b=0xFFFFFFFF -> 0x80000000. The matching REM -> 0.
// - Flush:
//   - mdu_flush=1 at an edge forces IDLE. No done is produced and mdu_result is unchanged.
//   - Flush takes priority over start in the same cycle.
// - Simultaneous start and done in the DONE state: done pulses for the old result; the new operation starts.
// STRUCTURE
// - Shared package mdu_pkg holds:
//   - MDU_OP_* localparams (the 8 funct3 codes).
//   - The state encoding (2 bits).
//   - MDU_ITER=32.
//   - The MDU_DIV0_Q=32'hFFFFFFFF constant.
// - Single flat module; no sub-module. Negation uses one shared two's-complement helper function defined in mdu_pkg.
// - Datapath registers: 64-bit accumulator (product, or remainder:quotient), 32-bit operand, 5-bit counter, sign flags.
// TESTING
// - MUL a=7, b=0xFFFFFFFD(-3), start at T -> done at T+34 only, result=0xFFFFFFEB; busy high T+1..T+33.
// - MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
// - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at T+2. DIVU a=100, b=0 -> 0xFFFFFFFF at T+2. REMU a=100, b=0 -> 100.
// - REM a=0xFFFFFFF9(-7), b=2 -> 0xFFFFFFFF. DIV a=-7, b=2 -> 0xFFFFFFFD. DIVU a=100, b=7 -> 14. REMU -> 2.
// - Start DIVU; assert flush at T+10 -> busy=0 at T+11; no done; result keeps its prior value.
//   Then start MUL 3*4 -> 12 at its T+34.
// - Drop rst_n asynchronously mid-CALC -> busy, done and result read 0 before the next edge.
//   Back-to-back: start asserted in DONE -> next done exactly 34 cycles later.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Holds the funct3 operation codes, FSM state encoding, iteration count,
// the divide-by-zero quotient, and the two's-complement helper.
package mdu_pkg;

    localparam int XLEN     = 32;
    localparam int MDU_ITER = 32;

    localparam logic [2:0] MDU_OP_MUL    = 3'b000;
    localparam logic [2:0] MDU_OP_MULH   = 3'b001;
    localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
    localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
    localparam logic [2:0] MDU_OP_DIV    = 3'b100;
    localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
    localparam logic [2:0] MDU_OP_REM    = 3'b110;
    localparam logic [2:0] MDU_OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] MDU_DIV0_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // Two's-complement negation; 32-bit users zero-extend and truncate.
    function automatic logic [63:0] mdu_neg(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
//   mdu_start/op/a/b/flush : EX stage -> unit (request, operands, abort)
//   mdu_busy/done/result   : unit -> EX stage (stall, completion pulse, value)
interface mdu_iter_if;
    import mdu_pkg::*;

    logic            mdu_start;
    logic [2:0]      mdu_op;
    logic [XLEN-1:0] mdu_a;
    logic [XLEN-1:0] mdu_b;
    logic            mdu_flush;
    logic            mdu_busy;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_result;

    modport master (
        output mdu_start, mdu_op, mdu_a, mdu_b, mdu_flush,
        input  mdu_busy, mdu_done, mdu_result
    );

    modport slave (
        input  mdu_start, mdu_op, mdu_a, mdu_b, mdu_flush,
        output mdu_busy, mdu_done, mdu_result
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one shift-add (multiply) or
// restoring shift-subtract (divide) step per cycle on operand magnitudes,
// sign-corrected when the result is captured.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mdu_iter_if.slave (start/op/a/b/flush in; busy/done/result out)
module mdu_iter
    import mdu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    mdu_iter_if.slave  bus
);

    mdu_state_e  state_q, state_d;
    logic [2:0]  op_q,    op_d;
    logic [63:0] acc_q,   acc_d;    // product, or remainder:quotient
    logic [31:0] opnd_q,  opnd_d;   // raw B in PREP, then |B|
    logic [4:0]  cnt_q,   cnt_d;
    logic        neg_q,   neg_d;    // final value must be negated
    logic [31:0] result_q, result_d;

    logic        is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_in, b_in, a_mag, b_mag;
    logic        spec_hit;
    logic [31:0] spec_res;
    logic [32:0] mul_sum, div_trial;
    logic [63:0] mul_step, div_step, calc_step, prod;
    logic [31:0] div_sel, div_res, calc_res;

    assign is_div = op_q[2];
    assign is_rem = op_q[1];

    // PREP view: A was parked in the low accumulator half, B in opnd_q.
    assign a_in = acc_q[31:0];
    assign b_in = opnd_q;

    assign a_signed = (op_q == MDU_OP_MULH) || (op_q == MDU_OP_MULHSU) ||
                      (op_q == MDU_OP_DIV)  || (op_q == MDU_OP_REM);
    assign b_signed = (op_q == MDU_OP_MULH) || (op_q == MDU_OP_DIV) ||
                      (op_q == MDU_OP_REM);
    assign a_neg    = a_signed & a_in[31];
    assign b_neg    = b_signed & b_in[31];
    assign a_mag    = a_neg ? 32'(mdu_neg({32'd0, a_in})) : a_in;
    assign b_mag    = b_neg ? 32'(mdu_neg({32'd0, b_in})) : b_in;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        spec_hit = 1'b0;
        spec_res = '0;
        if (is_div && b_in == 32'd0) begin
            spec_hit = 1'b1;
            spec_res = is_rem ? a_in : MDU_DIV0_Q;
        end else if ((op_q == MDU_OP_DIV || op_q == MDU_OP_REM) &&
                     a_in == 32'h8000_0000 && b_in == 32'hFFFF_FFFF) begin
            spec_hit = 1'b1;
            spec_res = is_rem ? 32'd0 : 32'h8000_0000;
        end
    end

    // Multiply: add |B| when the multiplier LSB is set, then shift right;
    // the 33-bit sum keeps the carry that shifts into bit 63.
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_step = {mul_sum, acc_q[31:1]};

    // Divide: shifted partial remainder minus |B|; a borrow means restore.
    assign div_trial = acc_q[63:31] - {1'b0, opnd_q};
    assign div_step  = div_trial[32] ? {acc_q[62:0], 1'b0}
                                     : {div_trial[31:0], acc_q[30:0], 1'b1};

    assign calc_step = is_div ? div_step : mul_step;

    // Sign correction of the value produced by the final iteration.
    assign prod     = neg_q ? mdu_neg(calc_step) : calc_step;
    assign div_sel  = is_rem ? calc_step[63:32] : calc_step[31:0];
    assign div_res  = neg_q ? 32'(mdu_neg({32'd0, div_sel})) : div_sel;
    assign calc_res = is_div ? div_res
                    : (op_q == MDU_OP_MUL) ? prod[31:0] : prod[63:32];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.mdu_start) begin
                    op_d    = bus.mdu_op;
                    acc_d   = {32'd0, bus.mdu_a};
                    opnd_d  = bus.mdu_b;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                if (spec_hit) begin
                    result_d = spec_res;
                    state_d  = ST_DONE;
                end else begin
                    acc_d   = {32'd0, a_mag};
                    opnd_d  = b_mag;
                    // Remainder follows the dividend; everything else is
                    // negative when exactly one operand is.
                    neg_d   = (is_div && is_rem) ? a_neg : (a_neg ^ b_neg);
                    cnt_d   = 5'(MDU_ITER - 1);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = calc_step;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    result_d = calc_res;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over any start and never disturbs the held result.
        if (bus.mdu_flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    // NOTE: all datapath registers, not just the FSM, are cleared on reset so
    // the unit comes up with a defined, zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign bus.mdu_busy   = (state_q == ST_PREP) || (state_q == ST_CALC);
    assign bus.mdu_done   = (state_q == ST_DONE);
    assign bus.mdu_result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed table of vectors, randomized
// operations against an arithmetic reference model, and hand sequences for
// flush, asynchronous reset and back-to-back starts.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    mdu_iter_if bus();

    mdu_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic from the instruction rules.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sbu;
        logic [63:0]        p;
        logic signed [31:0] sa32, sb32, sq;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        sbu  = {32'd0, b};
        sa32 = a;
        sb32 = b;
        case (op)
            MDU_OP_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            MDU_OP_MULH:   begin p = sa * sb;                 return p[63:32]; end
            MDU_OP_MULHSU: begin p = sa * sbu;                return p[63:32]; end
            MDU_OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            MDU_OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sq = sa32 / sb32;
                return sq;
            end
            MDU_OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MDU_OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sq = sa32 % sb32;
                return sq;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 2;
        if ((op == MDU_OP_DIV || op == MDU_OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Issue one request and wait (bounded) for done. Latency counts edges
    // after the sampling edge. With noise set, start is held high with
    // garbage operands while the operation is expected to be busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input bit noise,
                          output logic [31:0] res, output int lat, output bit busy_ok);
        @(negedge clk);
        bus.mdu_start = 1'b1;
        bus.mdu_op    = op;
        bus.mdu_a     = a;
        bus.mdu_b     = b;
        @(posedge clk);
        #1;
        bus.mdu_start = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!bus.mdu_done && lat < 100) begin
            if (!bus.mdu_busy) busy_ok = 1'b0;
            if (noise && lat < exp_lat) begin
                @(negedge clk);
                bus.mdu_start = 1'b1;
                bus.mdu_op    = 3'($urandom);
                bus.mdu_a     = $urandom;
                bus.mdu_b     = $urandom;
            end
            @(posedge clk);
            #1;
            bus.mdu_start = 1'b0;
            lat++;
        end
        if (bus.mdu_busy) busy_ok = 1'b0;
        res = bus.mdu_result;
    endtask

    task automatic apply(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit noise);
        logic [31:0] res;
        int          lat;
        bit          busy_ok;
        int          exp_lat;
        exp_lat = ref_lat(op, a, b);
        run_op(op, a, b, exp_lat, noise, res, lat, busy_ok);
        check($sformatf("%s op%0d a=%h b=%h result", tag, op, a, b), res, ref_res(op, a, b));
        check($sformatf("%s op%0d latency", tag, op), 32'(lat), 32'(exp_lat));
        check($sformatf("%s op%0d busy window", tag, op), {31'd0, busy_ok}, 32'd1);
        @(posedge clk);
        #1;
        check($sformatf("%s op%0d done one-cycle", tag, op), {31'd0, bus.mdu_done}, 32'd0);
    endtask

    initial begin
        vec_t        tbl[15];
        logic [31:0] res;
        int          lat;
        bit          busy_ok;
        bit          seen_done;

        bus.mdu_start = 1'b0;
        bus.mdu_op    = '0;
        bus.mdu_a     = '0;
        bus.mdu_b     = '0;
        bus.mdu_flush = 1'b0;

        tbl[0]  = '{MDU_OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        tbl[1]  = '{MDU_OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
        tbl[2]  = '{MDU_OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        tbl[3]  = '{MDU_OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
        tbl[4]  = '{MDU_OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
        tbl[5]  = '{MDU_OP_DIVU,   32'd100,        32'd0,         32'hFFFF_FFFF, 2};
        tbl[6]  = '{MDU_OP_REMU,   32'd100,        32'd0,         32'd100,       2};
        tbl[7]  = '{MDU_OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
        tbl[8]  = '{MDU_OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
        tbl[9]  = '{MDU_OP_DIVU,   32'd100,        32'd7,         32'd14,        34};
        tbl[10] = '{MDU_OP_REMU,   32'd100,        32'd7,         32'd2,         34};
        tbl[11] = '{MDU_OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2};
        tbl[12] = '{MDU_OP_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 2};
        tbl[13] = '{MDU_OP_DIV,    32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         34};
        tbl[14] = '{MDU_OP_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         34};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   {31'd0, bus.mdu_busy}, 32'd0);
        check("reset done",   {31'd0, bus.mdu_done}, 32'd0);
        check("reset result", bus.mdu_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_lat, (i % 2) == 1, res, lat, busy_ok);
            check($sformatf("table[%0d] result", i), res, tbl[i].exp_res);
            check($sformatf("table[%0d] latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("table[%0d] busy window", i), {31'd0, busy_ok}, 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("table[%0d] done one-cycle", i), {31'd0, bus.mdu_done}, 32'd0);
        end

        // Randomized against the model, with corner operands mixed in
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            apply("rand", op, a, b, (i % 3) == 0);
        end

        // Flush mid-divide: no done, result keeps prior value
        apply("pre-flush", MDU_OP_MUL, 32'd7, 32'hFFFF_FFFD, 1'b0);
        @(negedge clk);
        bus.mdu_start = 1'b1;
        bus.mdu_op    = MDU_OP_DIVU;
        bus.mdu_a     = 32'd1000;
        bus.mdu_b     = 32'd3;
        @(posedge clk);
        #1;
        bus.mdu_start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("busy before flush", {31'd0, bus.mdu_busy}, 32'd1);
        bus.mdu_flush = 1'b1;
        bus.mdu_start = 1'b1;   // flush must win over start
        @(posedge clk);
        #1;
        bus.mdu_flush = 1'b0;
        bus.mdu_start = 1'b0;
        check("busy after flush", {31'd0, bus.mdu_busy}, 32'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.mdu_done) seen_done = 1'b1;
        end
        check("no done after flush", {31'd0, seen_done}, 32'd0);
        check("result held after flush", bus.mdu_result, 32'hFFFF_FFEB);
        apply("post-flush", MDU_OP_MUL, 32'd3, 32'd4, 1'b0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        bus.mdu_start = 1'b1;
        bus.mdu_op    = MDU_OP_MUL;
        bus.mdu_a     = 32'd5;
        bus.mdu_b     = 32'd6;
        @(posedge clk);
        #1;
        bus.mdu_start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset busy",   {31'd0, bus.mdu_busy}, 32'd0);
        check("async reset done",   {31'd0, bus.mdu_done}, 32'd0);
        check("async reset result", bus.mdu_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back: start asserted in DONE
        run_op(MDU_OP_DIVU, 32'd100, 32'd7, 34, 1'b0, res, lat, busy_ok);
        check("b2b first result",  res, 32'd14);
        check("b2b first latency", 32'(lat), 32'd34);
        @(negedge clk);
        bus.mdu_start = 1'b1;
        bus.mdu_op    = MDU_OP_MUL;
        bus.mdu_a     = 32'd3;
        bus.mdu_b     = 32'd5;
        @(posedge clk);
        #1;
        bus.mdu_start = 1'b0;
        check("b2b restart busy", {31'd0, bus.mdu_busy}, 32'd1);
        lat = 1;
        while (!bus.mdu_done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b second latency", 32'(lat), 32'd34);
        check("b2b second result",  bus.mdu_result, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
